// File: rtl/gemips_pkg.sv
// Shared fetch-side types and defaults: reset vector, fetch increment,
// PC-generator state encoding and redirect source kinds.
package gemips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int          INC_DEF      = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_EXC    = 2'd2
    } redir_kind_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect requests, stall/ready handshake in,
// fetch address and status out. master = pc_gen, slave = pipeline/memory side.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              exc_flag_i;
    logic [ADDR_W-1:0] exc_addr_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_address_i;
    logic              stall_i;
    logic              imem_ready_i;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              redirect_pend_o;
    logic              misalign_o;

    modport master (
        input  exc_flag_i, exc_addr_i, branch_flag_i, branch_address_i,
        input  stall_i, imem_ready_i,
        output pc, ce, redirect_pend_o, misalign_o
    );

    modport slave (
        output exc_flag_i, exc_addr_i, branch_flag_i, branch_address_i,
        output stall_i, imem_ready_i,
        input  pc, ce, redirect_pend_o, misalign_o
    );
endinterface

// File: rtl/pc_redirect_pend.sv
// Pending-redirect register plus priority merge: new exception > new branch >
// pending redirect. Redirects seen while stalled are parked until release.
module pc_redirect_pend
    import gemips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              exc_only_i,
    input  logic              exc_flag_i,
    input  logic [ADDR_W-1:0] exc_addr_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              apply_vld_o,
    output logic [ADDR_W-1:0] apply_tgt_o,
    output logic              pend_vld_o
);

    redir_kind_e       pend_kind_q, pend_kind_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    always_comb begin
        pend_kind_d = pend_kind_q;
        pend_tgt_d  = pend_tgt_q;
        apply_vld_o = 1'b0;
        apply_tgt_o = pend_tgt_q;

        // A parked exception may only be displaced by another exception.
        if (stall_i) begin
            if (exc_flag_i) begin
                pend_kind_d = RD_EXC;
                pend_tgt_d  = exc_addr_i;
            end else if (branch_flag_i && (pend_kind_q != RD_EXC)) begin
                pend_kind_d = RD_BRANCH;
                pend_tgt_d  = branch_addr_i;
            end
        end else begin
            pend_kind_d = RD_NONE;
        end

        if (exc_flag_i) begin
            apply_vld_o = 1'b1;
            apply_tgt_o = exc_addr_i;
        end else if (branch_flag_i && !exc_only_i) begin
            apply_vld_o = 1'b1;
            apply_tgt_o = branch_addr_i;
        end else if ((pend_kind_q == RD_EXC) ||
                     ((pend_kind_q == RD_BRANCH) && !exc_only_i)) begin
            apply_vld_o = 1'b1;
            apply_tgt_o = pend_tgt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pend_kind_q <= RD_NONE;
        else      pend_kind_q <= pend_kind_d;
    end

    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

    assign pend_vld_o = (pend_kind_q != RD_NONE);

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch address generator with ready/stall handshake and redirects.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets park the unit in FAULT.
module pc_gen
    import gemips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                INC      = INC_DEF,
    parameter int                ALIGN    = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    if ((ALIGN < 1) || ((ALIGN & (ALIGN - 1)) != 0)) begin : g_align_chk
        $error("pc_gen: ALIGN must be a power of two");
    end

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              apply_vld;
    logic [ADDR_W-1:0] apply_tgt;
    logic              pend_vld;

`ifdef PC_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return (a & ADDR_W'(ALIGN - 1)) != '0;
    endfunction
`endif

    pc_redirect_pend #(
        .ADDR_W (ADDR_W)
    ) u_pend (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (bus.stall_i),
        .exc_only_i    (state_q == ST_FAULT),
        .exc_flag_i    (bus.exc_flag_i),
        .exc_addr_i    (bus.exc_addr_i),
        .branch_flag_i (bus.branch_flag_i),
        .branch_addr_i (bus.branch_address_i),
        .apply_vld_o   (apply_vld),
        .apply_tgt_o   (apply_tgt),
        .pend_vld_o    (pend_vld)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                // Redirects bypass imem_ready_i: the un-accepted fetch is dropped.
                if (!bus.stall_i && apply_vld) begin
                    pc_d    = apply_tgt;
                    state_d = ST_RUN;
`ifdef PC_ALIGN_CHECK_EN
                    if (is_misaligned(apply_tgt)) state_d = ST_FAULT;
`endif
                end else if (bus.stall_i || !bus.imem_ready_i) begin
                    state_d = ST_HOLD;
                end else begin
                    pc_d    = pc_q + ADDR_W'(INC);
                    state_d = ST_RUN;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            ST_FAULT: begin
                if (!bus.stall_i && apply_vld) begin
                    pc_d    = apply_tgt;
                    state_d = is_misaligned(apply_tgt) ? ST_FAULT : ST_RUN;
                end
            end
`endif
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.ce              = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.redirect_pend_o = pend_vld;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign_o      = (state_q == ST_FAULT);
`else
    assign bus.misalign_o      = 1'b0;
`endif

endmodule
